// File: rtl/ex_mem_stage_pkg.sv
// Shared processor header: EX/MEM FSM encoding and entry-record sizing.
package ex_mem_stage_pkg;

    typedef enum logic {
        StRun  = 1'b0,
        StTrap = 1'b1
    } state_e;

    localparam int unsigned DataWDef = 32;
    localparam int unsigned RdWDef   = 5;

    // Entry record: {result, pc, rd, regwrite}
    function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned rd_w);
        return 2 * data_w + rd_w + 1;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; slot e0 is always the head. flush empties it.
module skid_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    // Never overwrite a full buffer or pop an empty one.
    assign push_ok = push & (count_q != 2'd2);
    assign pop_ok  = pop & (count_q != 2'd0);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = din;
                    else                 e1_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign dout  = e0_q;
    assign count = count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: 2-deep skid buffer plus branch-redirect and overflow-trap pulses.
// Define OVERFLOW_TRAP_EN to enable the overflow trap (RUN/TRAP FSM, exc_ov/exc_epc).
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned RD_W   = RdWDef
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_overflow,
    input  logic              alu_cmp,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_ovf_chk,
    input  logic              ex_is_branch,
    input  logic [DATA_W-1:0] ex_br_target,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_pc,
    output logic [RD_W-1:0]   mem_rd,
    output logic              mem_regwrite,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              exc_ov,
    output logic [DATA_W-1:0] exc_epc
);

    localparam int unsigned EntryW = entry_w(DATA_W, RD_W);

    state_e            state_q, state_d;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;
    logic [1:0]        count;
    logic              push, pop, trap_push;
    logic [EntryW-1:0] din, dout;

    assign ex_ready  = (count != 2'd2) && (state_q == StRun);
    assign mem_valid = (count != 2'd0);
    // flush kills any same-cycle push, so its side effects are masked here too.
    assign push      = ex_valid & ex_ready & ~flush;
    assign pop       = mem_valid & mem_ready & ~flush;

`ifdef OVERFLOW_TRAP_EN
    logic              exc_ov_q, exc_ov_d;
    logic [DATA_W-1:0] exc_epc_q, exc_epc_d;

    assign trap_push = push & ex_ovf_chk & alu_overflow;

    always_comb begin
        exc_ov_d  = trap_push;
        exc_epc_d = trap_push ? ex_pc : exc_epc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_ov_q  <= 1'b0;
            exc_epc_q <= '0;
        end else begin
            exc_ov_q  <= exc_ov_d;
            exc_epc_q <= exc_epc_d;
        end
    end

    assign exc_ov  = exc_ov_q;
    assign exc_epc = exc_epc_q;
`else
    logic unused_trap;
    assign unused_trap = ex_ovf_chk ^ alu_overflow;
    assign trap_push   = 1'b0;
    assign exc_ov      = 1'b0;
    assign exc_epc     = '0;
`endif

    assign din = {alu_c, ex_pc, ex_rd, ex_regwrite & ~trap_push};

    skid_buf2 #(
        .WIDTH(EntryW)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (push),
        .pop  (pop),
        .din  (din),
        .dout (dout),
        .count(count)
    );

    assign {mem_result, mem_pc, mem_rd, mem_regwrite} = dout;

    always_comb begin
        br_taken_d  = push & ex_is_branch & alu_cmp;
        br_target_d = br_taken_d ? ex_br_target : br_target_q;
        state_d     = state_q;
        if (flush)          state_d = StRun;
        else if (trap_push) state_d = StTrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q     <= state_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table, directed corner cases, random vs queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ex_valid = 1'b0;
    logic        alu_overflow = 1'b0, alu_cmp = 1'b0, ex_regwrite = 1'b0;
    logic        ex_ovf_chk = 1'b0, ex_is_branch = 1'b0, mem_ready = 1'b0;
    logic [31:0] alu_c = '0, ex_pc = '0, ex_br_target = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_ready, mem_valid, mem_regwrite, br_taken, exc_ov;
    logic [31:0] mem_result, mem_pc, br_target, exc_epc;
    logic [4:0]  mem_rd;

    ex_mem_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_c(alu_c), .alu_overflow(alu_overflow), .alu_cmp(alu_cmp), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_ovf_chk(ex_ovf_chk),
        .ex_is_branch(ex_is_branch), .ex_br_target(ex_br_target), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_result(mem_result), .mem_pc(mem_pc), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .br_taken(br_taken), .br_target(br_target),
        .exc_ov(exc_ov), .exc_epc(exc_epc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a FIFO of at most two records plus trap flag and pulse registers.
    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
    } ent_t;

    ent_t        mq[$];
    bit          m_trap = 0, m_br = 0, m_exc = 0;
    logic [31:0] m_bt = '0, m_epc = '0;

    task automatic model_check(input string tag);
        bit rdy;
        rdy = (mq.size() < 2) && !m_trap;
        check({tag, " ready"}, ex_ready, rdy);
        check({tag, " mem_valid"}, mem_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check({tag, " result"}, mem_result, mq[0].res);
            check({tag, " pc"}, mem_pc, mq[0].pc);
            check({tag, " rd"}, mem_rd, mq[0].rd);
            check({tag, " regwrite"}, mem_regwrite, mq[0].rw);
        end
        check({tag, " br_taken"}, br_taken, m_br);
        if (m_br) check({tag, " br_target"}, br_target, m_bt);
        check({tag, " exc_ov"}, exc_ov, m_exc);
`ifdef OVERFLOW_TRAP_EN
        if (m_exc) check({tag, " exc_epc"}, exc_epc, m_epc);
`else
        check({tag, " exc_epc"}, exc_epc, 32'h0);
`endif
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit   rdy, psh, pp, ovf;
        ent_t tmp;
        rdy = (mq.size() < 2) && !m_trap;
        psh = ex_valid && rdy && !flush;
        pp  = (mq.size() != 0) && mem_ready && !flush;
        ovf = 0;
`ifdef OVERFLOW_TRAP_EN
        ovf = psh && ex_ovf_chk && alu_overflow;
`endif
        if (flush) begin
            mq.delete();
            m_trap = 0;
            m_br   = 0;
            m_exc  = 0;
        end else begin
            if (pp) tmp = mq.pop_front();
            if (psh) begin
                tmp.res = alu_c;
                tmp.pc  = ex_pc;
                tmp.rd  = ex_rd;
                tmp.rw  = ex_regwrite && !ovf;
                mq.push_back(tmp);
            end
            m_br = psh && ex_is_branch && alu_cmp;
            if (m_br) m_bt = ex_br_target;
            m_exc = ovf;
            if (ovf) begin
                m_epc  = ex_pc;
                m_trap = 1;
            end
        end
    endtask

    typedef struct {
        logic        fl, v, mr, br, cmp;
        logic [31:0] c;
        logic        e_rdy, e_mv, e_br;
        logic [31:0] e_res;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        //           fl v  mr br cmp c             rdy mv br res
        tbl[0]  = '{0, 1, 0, 0, 0, 32'hA1,       1, 1, 0, 32'hA1};
        tbl[1]  = '{0, 1, 0, 0, 0, 32'hA2,       0, 1, 0, 32'hA1};
        tbl[2]  = '{0, 1, 0, 0, 0, 32'hA3,       0, 1, 0, 32'hA1};
        tbl[3]  = '{0, 1, 1, 0, 0, 32'hA3,       1, 1, 0, 32'hA2};
        tbl[4]  = '{0, 1, 1, 0, 0, 32'hA3,       1, 1, 0, 32'hA3};
        tbl[5]  = '{0, 0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0};
        tbl[6]  = '{0, 1, 1, 0, 0, 32'h12345678, 1, 1, 0, 32'h12345678};
        tbl[7]  = '{0, 0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0};
        tbl[8]  = '{0, 1, 0, 0, 0, 32'hB1,       1, 1, 0, 32'hB1};
        tbl[9]  = '{0, 1, 0, 0, 0, 32'hB2,       0, 1, 0, 32'hB1};
        tbl[10] = '{1, 1, 0, 1, 1, 32'hB3,       1, 0, 0, 32'h0};
        tbl[11] = '{0, 1, 0, 0, 0, 32'hC1,       1, 1, 0, 32'hC1};
        tbl[12] = '{1, 1, 0, 1, 1, 32'hC2,       1, 0, 0, 32'h0};
        tbl[13] = '{0, 1, 1, 1, 1, 32'hD1,       1, 1, 1, 32'hD1};
        tbl[14] = '{0, 0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0};
        tbl[15] = '{0, 1, 1, 1, 0, 32'hD2,       1, 1, 0, 32'hD2};
        tbl[16] = '{0, 0, 1, 0, 0, 32'h0,        1, 0, 0, 32'h0};

        // Reset values while rst_n is held low.
        #1;
        check("rst mem_valid", mem_valid, 0);
        check("rst br_taken", br_taken, 0);
        check("rst exc_ov", exc_ov, 0);
        check("rst mem_result", mem_result, 0);
        check("rst mem_pc", mem_pc, 0);
        check("rst mem_rd", mem_rd, 0);
        check("rst mem_regwrite", mem_regwrite, 0);
        check("rst br_target", br_target, 0);
        check("rst exc_epc", exc_epc, 0);

        @(negedge clk);
        rst_n        = 1'b1;
        ex_rd        = 5'd3;
        ex_regwrite  = 1'b1;
        ex_br_target = 32'h0040_0100;

        for (int i = 0; i < 17; i++) begin
            flush        = tbl[i].fl;
            ex_valid     = tbl[i].v;
            mem_ready    = tbl[i].mr;
            ex_is_branch = tbl[i].br;
            alu_cmp      = tbl[i].cmp;
            alu_c        = tbl[i].c;
            ex_pc        = 32'h0040_0000 + 32'(i * 4);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d ready", i), ex_ready, tbl[i].e_rdy);
            check($sformatf("row%0d mem_valid", i), mem_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) begin
                check($sformatf("row%0d result", i), mem_result, tbl[i].e_res);
                check($sformatf("row%0d rd", i), mem_rd, 5'd3);
                check($sformatf("row%0d regwrite", i), mem_regwrite, 1'b1);
            end
            check($sformatf("row%0d br_taken", i), br_taken, tbl[i].e_br);
            if (tbl[i].e_br) check($sformatf("row%0d br_target", i), br_target, 32'h0040_0100);
            check($sformatf("row%0d exc_ov", i), exc_ov, 1'b0);
        end

        // Overflow push: traps only when the feature is built in.
        flush = 0; ex_is_branch = 0; alu_cmp = 0; mem_ready = 0;
        ex_valid = 1; ex_ovf_chk = 1; alu_overflow = 1; ex_pc = 32'h0040_0020; alu_c = 32'h7;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 0; ex_ovf_chk = 0; alu_overflow = 0;
        check("ovf mem_valid", mem_valid, 1);
`ifdef OVERFLOW_TRAP_EN
        check("ovf exc_ov", exc_ov, 1);
        check("ovf exc_epc", exc_epc, 32'h0040_0020);
        check("ovf regwrite", mem_regwrite, 0);
        check("ovf ready", ex_ready, 0);
        mem_ready = 1; ex_valid = 1;
        @(posedge clk);
        @(negedge clk);
        check("trap exc_ov pulse", exc_ov, 0);
        check("trap drained", mem_valid, 0);
        check("trap ready", ex_ready, 0);
        flush = 1; ex_valid = 0;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        check("trap flush ready", ex_ready, 1);
`else
        check("ovf exc_ov", exc_ov, 0);
        check("ovf exc_epc", exc_epc, 0);
        check("ovf regwrite", mem_regwrite, 1);
        check("ovf ready", ex_ready, 1);
        mem_ready = 1;
        @(posedge clk);
        @(negedge clk);
        check("ovf drained", mem_valid, 0);
`endif

        // Asynchronous reset with two buffered entries.
        mem_ready = 0; ex_valid = 1; alu_c = 32'hE0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre-rst full", ex_ready, 0);
        rst_n = 1'b0;
        #1;
        check("async rst mem_valid", mem_valid, 0);
        check("async rst mem_result", mem_result, 0);
        check("async rst br_taken", br_taken, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst ready", ex_ready, 1);
        alu_c = 32'hE1;
        @(posedge clk);
        @(negedge clk);
        check("post-rst mem_valid", mem_valid, 1);
        check("post-rst result", mem_result, 32'hE1);

        // Sync model and DUT with a flush, then run random traffic.
        ex_valid = 0; flush = 1;
        model_step();
        @(posedge clk);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            model_check($sformatf("rnd%0d", n));
            flush        = ($urandom_range(0, 19) == 0);
            ex_valid     = ($urandom_range(0, 3) != 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            alu_c        = $urandom;
            ex_pc        = $urandom;
            ex_br_target = $urandom;
            ex_rd        = 5'($urandom);
            ex_regwrite  = 1'($urandom);
            ex_is_branch = 1'($urandom);
            alu_cmp      = 1'($urandom);
            ex_ovf_chk   = ($urandom_range(0, 3) == 0);
            alu_overflow = ($urandom_range(0, 3) == 0);
            model_step();
            @(posedge clk);
        end
        @(negedge clk);
        model_check("rnd final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
